// File: rtl/citron_pkg.sv
// citron_pkg: shared definitions for the Citron device-bus arbiter.
//   CITRON_ADDR_W / CITRON_DATA_W : default bus widths.
//   CITRON_ERR_DATA               : read data returned on a WAIT timeout
//                                   (CITRON_ARB_TIMEOUT_EN builds only).
//   citron_arb_state_t            : arbiter sequencer states.
//   citron_master_t               : requester identifiers.
package citron_pkg;

    localparam int unsigned CITRON_ADDR_W   = 8;
    localparam int unsigned CITRON_DATA_W   = 32;
    localparam logic [31:0] CITRON_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } citron_arb_state_t;

    typedef enum logic {
        M0,
        M1
    } citron_master_t;

endpackage

// File: rtl/citron_rr_pick.sv
// citron_rr_pick: combinational two-way round-robin selector.
//   req   [1:0] in  : request vector, bit n = requester Mn.
//   last        in  : requester granted most recently.
//   grant       out : selected requester (meaningful when valid = 1).
//   valid       out : at least one request is present.
module citron_rr_pick
    import citron_pkg::*;
(
    input  logic [1:0]     req,
    input  citron_master_t last,
    output citron_master_t grant,
    output logic           valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            // Contention: the requester that did not go last wins.
            grant = (last == M0) ? M1 : M0;
        end else if (req[1]) begin
            grant = M1;
        end else begin
            grant = M0;
        end
    end

endmodule

// File: rtl/citron_bus_arbiter.sv
// citron_bus_arbiter: two-requester arbiter and sequencer for the Citron bus.
//   clk_i, rst_ni              : clock, synchronous active-low reset.
//   mX_req_i/addr_i/wr_i/wdata_i : requester X command, held until its ack.
//   mX_ack_o/rdata_o/err_o     : one-cycle completion pulse with read data and
//                                error flag; data/err hold between acks.
//   citron_addr_o/rdy_o/wr_o/writedata_o : bus command, rdy is a 1-cycle strobe.
//   citron_readdata_i/stall_i/match_i    : OR-combined device responses.
// Optional: define CITRON_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES cycles,
// after which the requester gets err = 1 and CITRON_ERR_DATA.
module citron_bus_arbiter
    import citron_pkg::*;
#(
    parameter int unsigned ADDR_W         = CITRON_ADDR_W,
    parameter int unsigned DATA_W         = CITRON_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_wr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_wr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] citron_addr_o,
    output logic              citron_rdy_o,
    output logic              citron_wr_o,
    output logic [DATA_W-1:0] citron_writedata_o,
    input  logic [DATA_W-1:0] citron_readdata_i,
    input  logic              citron_stall_i,
    input  logic              citron_match_i
);

    citron_arb_state_t state_q, state_d;
    citron_master_t    grant_q, grant_d;
    citron_master_t    rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;

    citron_master_t    pick_grant;
    logic              pick_valid;

    // Completion of the current transfer, resolved in ISSUE or WAIT.
    logic              finish;
    logic              fin_err;
    logic [DATA_W-1:0] fin_data;

`ifdef CITRON_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    citron_rr_pick u_pick (
        .req   ({m1_req_i, m0_req_i}),
        .last  (rr_last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rdy_d      = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_err_d   = m0_err_q;
        m1_err_d   = m1_err_q;
        finish     = 1'b0;
        fin_err    = 1'b0;
        fin_data   = '0;
`ifdef CITRON_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    if (pick_grant == M1) begin
                        addr_d  = m1_addr_i;
                        wr_d    = m1_wr_i;
                        wdata_d = m1_wdata_i;
                    end else begin
                        addr_d  = m0_addr_i;
                        wr_d    = m0_wr_i;
                        wdata_d = m0_wdata_i;
                    end
                    rdy_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!citron_match_i) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (wr_q) begin
                    finish = 1'b1;
                end else if (!citron_stall_i) begin
                    finish   = 1'b1;
                    fin_data = citron_readdata_i;
                end else begin
                    state_d = WAIT;
`ifdef CITRON_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                // Stall release wins over a coincident timeout.
                if (!citron_stall_i) begin
                    finish   = 1'b1;
                    fin_data = citron_readdata_i;
                end
`ifdef CITRON_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    finish   = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = DATA_W'(CITRON_ERR_DATA);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rr_last_d = grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ack and response data are registered on entry to RESP.
        if (finish) begin
            state_d = RESP;
            if (grant_q == M0) begin
                m0_ack_d   = 1'b1;
                m0_rdata_d = fin_data;
                m0_err_d   = fin_err;
            end else begin
                m1_ack_d   = 1'b1;
                m1_rdata_d = fin_data;
                m1_err_d   = fin_err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= M0;
            rr_last_q  <= M1;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rdy_q      <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`ifdef CITRON_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rdy_q      <= rdy_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
`ifdef CITRON_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign m0_ack_o           = m0_ack_q;
    assign m0_rdata_o         = m0_rdata_q;
    assign m0_err_o           = m0_err_q;
    assign m1_ack_o           = m1_ack_q;
    assign m1_rdata_o         = m1_rdata_q;
    assign m1_err_o           = m1_err_q;
    assign citron_addr_o      = addr_q;
    assign citron_rdy_o       = rdy_q;
    assign citron_wr_o        = wr_q;
    assign citron_writedata_o = wdata_q;

endmodule

// File: tb/tb_citron_bus_arbiter.sv
// tb_citron_bus_arbiter: directed bench for citron_bus_arbiter with a
// transaction-timeline reference model and a per-cycle compare process.
module tb_citron_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_wr, m1_wr;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [7:0]  c_addr;
    logic        c_rdy, c_wr;
    logic [31:0] c_wdata, c_rdata;
    logic        c_stall, c_match;

    always #5 clk = ~clk;

    citron_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wr_i(m0_wr), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wr_i(m1_wr), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .citron_addr_o(c_addr), .citron_rdy_o(c_rdy), .citron_wr_o(c_wr),
        .citron_writedata_o(c_wdata), .citron_readdata_i(c_rdata),
        .citron_stall_i(c_stall), .citron_match_i(c_match)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        int          stall_n;   // cycles the device holds stall high from the rdy strobe
    } op_t;

    op_t q0[$], q1[$];

    // Model: each transaction is a point on a timeline (issue, ack cycles).
    int          cyc = 0;
    bit          idle_cur = 1, busy = 0, rr_last = 1, m_w = 0, pop0 = 0, pop1 = 0;
    op_t         cur;
    int          issue_c = 0, ack_c = 0;
    logic        e_rdy = 0, e_wr = 0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic        e_ack[2], e_err[2];
    logic [31:0] e_rdata[2];

    int total = 0, bad = 0;
    bit chk_en = 0;
    int ack_log[$], rdy_log[$];
    int ack_cyc0 = -1, ack_cyc1 = -1;
    logic [7:0]  rdy_addr;
    logic        rdy_wr;
    logic [31:0] rdy_wdata;

    function automatic logic [31:0] rd(input logic [7:0] a);
        return {8'h00, a, 8'h00, 8'h42};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_exp();
        e_rdy = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = 0; e_err[i] = 0; e_rdata[i] = '0;
        end
    endtask

    // Advance the model into cycle cyc using the inputs held during cyc-1.
    task automatic model_update();
        int  n;
        bit  match, tmo;
        cyc++;
        e_rdy = 0; e_ack[0] = 0; e_ack[1] = 0;
        if (pop0) begin void'(q0.pop_front()); pop0 = 0; end
        if (pop1) begin void'(q1.pop_front()); pop1 = 0; end
        if (!rst_n) begin
            if (busy && (cyc - 1) < ack_c) begin
                if (m_w) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            busy = 0; idle_cur = 1; rr_last = 1;
            clear_exp();
            return;
        end
        if (idle_cur) begin
            if (m0_req || m1_req) begin
                m_w   = (m0_req && m1_req) ? !rr_last : m1_req;
                cur   = m_w ? q1[0] : q0[0];
                match = (cur.addr != 8'hFF);
                n     = (!match || cur.wr) ? 0 : cur.stall_n;
                issue_c = cyc;
                ack_c   = cyc + 1 + n;
`ifdef CITRON_ARB_TIMEOUT_EN
                if (n > TO) ack_c = cyc + 1 + TO;
`endif
                busy = 1; idle_cur = 0;
                e_addr = cur.addr; e_wr = cur.wr; e_wdata = cur.wdata; e_rdy = 1;
            end
        end else if (busy) begin
            if (cyc == ack_c) begin
                match = (cur.addr != 8'hFF);
                tmo = 0;
`ifdef CITRON_ARB_TIMEOUT_EN
                tmo = match && !cur.wr && (cur.stall_n > TO);
`endif
                e_ack[m_w]   = 1;
                e_err[m_w]   = !match || tmo;
                e_rdata[m_w] = !match ? 32'h0 : tmo ? 32'hDEAD_BEEF : cur.wr ? 32'h0 : rd(cur.addr);
                rr_last = m_w;
                if (m_w) pop1 = 1; else pop0 = 1;
            end else if (cyc == ack_c + 1) begin
                busy = 0; idle_cur = 1;
            end
        end
    endtask

    // Requesters present their queue heads; the device answers the latched address.
    task automatic drive();
        m0_req = (q0.size() > 0);
        m0_addr = m0_req ? q0[0].addr : '0;
        m0_wr = m0_req ? q0[0].wr : 1'b0;
        m0_wdata = m0_req ? q0[0].wdata : '0;
        m1_req = (q1.size() > 0);
        m1_addr = m1_req ? q1[0].addr : '0;
        m1_wr = m1_req ? q1[0].wr : 1'b0;
        m1_wdata = m1_req ? q1[0].wdata : '0;
        c_stall = busy && (cyc >= issue_c) && (cyc < issue_c + cur.stall_n);
        c_match = (e_addr != 8'hFF);
        c_rdata = c_match ? rd(e_addr) : 32'hFFFF_FFFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        drive();
    endtask

    task automatic push(input bit m, input logic [7:0] a, input logic w,
                        input logic [31:0] d, input int s);
        op_t o;
        o.addr = a; o.wr = w; o.wdata = d; o.stall_n = s;
        if (m) q1.push_back(o); else q0.push_back(o);
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL run_idle budget expired cyc=%0d got=busy want=idle", cyc);
        end
    endtask

    task automatic clear_logs();
        ack_log.delete(); rdy_log.delete();
        ack_cyc0 = -1; ack_cyc1 = -1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdy", c_rdy, e_rdy);
            check("bus_addr", c_addr, e_addr);
            check("bus_wr", c_wr, e_wr);
            check("bus_wdata", c_wdata, e_wdata);
            check("m0_ack", m0_ack, e_ack[0]);
            check("m1_ack", m1_ack, e_ack[1]);
            check("m0_rdata", m0_rdata, e_rdata[0]);
            check("m1_rdata", m1_rdata, e_rdata[1]);
            check("m0_err", m0_err, e_err[0]);
            check("m1_err", m1_err, e_err[1]);
            if (m0_ack === 1'b1) begin ack_log.push_back(0); ack_cyc0 = cyc; end
            if (m1_ack === 1'b1) begin ack_log.push_back(1); ack_cyc1 = cyc; end
            if (c_rdy === 1'b1) begin
                rdy_log.push_back(cyc);
                rdy_addr = c_addr; rdy_wr = c_wr; rdy_wdata = c_wdata;
            end
        end
    end

    initial begin
        int t;
        clear_exp();
        rst_n = 1'b0;
        drive();
        step();
        chk_en = 1;
        step();
        rst_n = 1'b1;
        step();

        // M0 write; device stall is ignored for writes.
        clear_logs(); t = cyc;
        push(0, 8'h01, 1'b1, 32'h0000_00A5, 2);
        run_idle(40);
        check("t1_ack_lat", ack_cyc0 - t, 2);
        check("t1_model_lat", ack_c - t, 2);
        check("t1_rdy_cnt", rdy_log.size(), 1);
        check("t1_rdy_addr", rdy_addr, 8'h01);
        check("t1_rdy_wr", rdy_wr, 1'b1);
        check("t1_rdy_wdata", rdy_wdata, 32'hA5);
        check("t1_err", m0_err, 1'b0);

        // M1 read with three stall cycles.
        step(); clear_logs(); t = cyc;
        push(1, 8'h00, 1'b0, 32'h0, 3);
        run_idle(40);
        check("t2_ack_lat", ack_cyc1 - t, 5);
        check("t2_rdata", m1_rdata, 32'h0000_0042);
        check("t2_rdy_cnt", rdy_log.size(), 1);
        check("t2_m0_acks", ack_cyc0, -1);

        // Both requesting continuously: alternate grants.
        step(); clear_logs();
        push(0, 8'h10, 1'b0, 32'h0, 0);
        push(0, 8'h11, 1'b0, 32'h0, 2);
        push(1, 8'h20, 1'b0, 32'h0, 1);
        push(1, 8'h21, 1'b0, 32'h0, 0);
        run_idle(80);
        check("t3_ack_cnt", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check("t3_grant_order", ack_log[i], i % 2);
        for (int i = 1; i < rdy_log.size(); i++)
            check("t3_rdy_gap_ge3", (rdy_log[i] - rdy_log[i-1]) >= 3, 1);
        check("t3_m1_rdata", m1_rdata, 32'h0021_0042);
        check("t3_m0_rdata", m0_rdata, 32'h0011_0042);

        // Unmatched read with stall high: no WAIT.
        step(); clear_logs(); t = cyc;
        push(0, 8'hFF, 1'b0, 32'h0, 4);
        run_idle(40);
        check("t4_ack_lat", ack_cyc0 - t, 2);
        check("t4_err", m0_err, 1'b1);
        check("t4_rdata", m0_rdata, 32'h0);

        // Reset while in WAIT drops the transaction.
        step(); clear_logs(); t = cyc;
        push(1, 8'h30, 1'b0, 32'h0, 20);
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_rst_m1_rdata", m1_rdata, 32'h0);
        check("t5_rst_addr", c_addr, 8'h00);
        check("t5_rst_rdy", c_rdy, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("t5_no_ack", ack_log.size(), 0);
        push(1, 8'h31, 1'b0, 32'h0, 0);
        push(0, 8'h32, 1'b0, 32'h0, 0);
        run_idle(40);
        check("t5_first_grant", (ack_log.size() > 0) ? ack_log[0] : -1, 0);

`ifdef CITRON_ARB_TIMEOUT_EN
        // Stuck stall times out; stall dropping on the timeout cycle wins.
        step(); clear_logs(); t = cyc;
        push(0, 8'h40, 1'b0, 32'h0, 9);
        run_idle(40);
        check("t6_ack_lat", ack_cyc0 - t, 6);
        check("t6_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t6_err", m0_err, 1'b1);
        for (int i = 0; i < 10; i++) step();
        clear_logs(); t = cyc;
        push(0, 8'h41, 1'b0, 32'h0, 4);
        run_idle(40);
        check("t7_ack_lat", ack_cyc0 - t, 6);
        check("t7_rdata", m0_rdata, 32'h0041_0042);
        check("t7_err", m0_err, 1'b0);
`endif

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
